branch_predict_unit: RTL and testbench

Parametrised EX-stage branch resolution unit with a PC-indexed bimodal branch history table (BHT) of 2-bit saturating counters for the pipelined MIPS core. It gives an ID-stage prediction, resolves all eight conditional branches (BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL) in EX, and trains the table. It also emits a registered one-cycle mispredict pulse for the hazard/flush logic and keeps saturating performance counters.

---
 rtl/branch_predict_unit.sv | 134 +++++++++++++
 tb/tb_branch_predict_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolution with a PC-indexed bimodal 2-bit BHT.
// Emits a registered one-cycle mispredict pulse and saturating perf counters.
module branch_predict_unit #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 16
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    input  logic [PC_W-1:0]   iLookupPC,
    output logic              oPredTaken,
    input  logic              iResolveValid,
    input  logic              iBranch,
    input  logic              iStall,
    input  logic [5:0]        iOpcode,
    input  logic [4:0]        iRt,
    input  logic [DATA_W-1:0] iA,
    input  logic [DATA_W-1:0] iB,
    input  logic [PC_W-1:0]   iResolvePC,
    input  logic              iPredTaken,
    output logic              oTaken,
    output logic              oLink,
    output logic              oMispredict,
    output logic [PC_W-1:0]   oMispredictPC,
    output logic              oActualTaken,
    output logic [CNT_W-1:0]  oBranchCount,
    output logic [CNT_W-1:0]  oMissCount
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0]       r_bht [DEPTH];
    logic             r_miss;
    logic [PC_W-1:0]  r_missPC;
    logic             r_actual;
    logic [CNT_W-1:0] r_brCnt;
    logic [CNT_W-1:0] r_missCnt;

    logic [IDX_W-1:0] w_lkIdx;
    logic [IDX_W-1:0] w_rsIdx;
    logic             w_isBr;
    logic             w_cond;
    logic             w_link;
    logic             w_eq;
    logic             w_lt0;
    logic             w_eq0;
    logic             w_evt;
    logic             w_mis;
    logic             w_unused;

    assign w_lkIdx = iLookupPC[IDX_W+1:2];
    assign w_rsIdx = iResolvePC[IDX_W+1:2];
    assign w_unused = ^{iLookupPC[PC_W-1:IDX_W+2], iLookupPC[1:0],
                        iResolvePC[PC_W-1:IDX_W+2], iResolvePC[1:0]};

    assign oPredTaken = r_bht[w_lkIdx][1];

    // Sign bit and zero test give every signed compare against zero
    assign w_eq  = (iA == iB);
    assign w_lt0 = iA[DATA_W-1];
    assign w_eq0 = (iA == '0);

    always_comb begin
        w_isBr = 1'b0;
        w_cond = 1'b0;
        w_link = 1'b0;
        if (iBranch) begin
            case (iOpcode)
                6'b000100: begin w_isBr = 1'b1; w_cond = w_eq;  end
                6'b000101: begin w_isBr = 1'b1; w_cond = ~w_eq; end
                6'b000110: begin
                    w_isBr = (iRt == 5'd0);
                    w_cond = w_lt0 | w_eq0;
                end
                6'b000111: begin
                    w_isBr = (iRt == 5'd0);
                    w_cond = ~w_lt0 & ~w_eq0;
                end
                6'b000001: begin
                    case (iRt)
                        5'b00000: begin w_isBr = 1'b1; w_cond = w_lt0;  end
                        5'b00001: begin w_isBr = 1'b1; w_cond = ~w_lt0; end
                        5'b10000: begin
                            w_isBr = 1'b1; w_cond = w_lt0;  w_link = 1'b1;
                        end
                        5'b10001: begin
                            w_isBr = 1'b1; w_cond = ~w_lt0; w_link = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign oTaken = w_isBr & w_cond;
    assign oLink  = w_isBr & w_link;
    assign w_evt  = iResolveValid & ~iStall & w_isBr;
    assign w_mis  = w_evt & (oTaken != iPredTaken);

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            for (int i = 0; i < DEPTH; i++) r_bht[i] <= 2'b01;
            r_miss    <= 1'b0;
            r_missPC  <= '0;
            r_actual  <= 1'b0;
            r_brCnt   <= '0;
            r_missCnt <= '0;
        end else begin
            r_miss <= w_mis;
            if (w_evt) begin
                if (oTaken && r_bht[w_rsIdx] != 2'b11)
                    r_bht[w_rsIdx] <= r_bht[w_rsIdx] + 2'b01;
                else if (!oTaken && r_bht[w_rsIdx] != 2'b00)
                    r_bht[w_rsIdx] <= r_bht[w_rsIdx] - 2'b01;
                if (r_brCnt != '1) r_brCnt <= r_brCnt + 1'b1;
            end
            if (w_mis) begin
                r_missPC <= iResolvePC;
                r_actual <= oTaken;
                if (r_missCnt != '1) r_missCnt <= r_missCnt + 1'b1;
            end
        end
    end

    assign oMispredict   = r_miss;
    assign oMispredictPC = r_missPC;
    assign oActualTaken  = r_actual;
    assign oBranchCount  = r_brCnt;
    assign oMissCount    = r_missCnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit; a second instance with
// CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] lpc;
    logic        vld, br, stl, ptk;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] a, b, rpc;
    logic        pred, tkn, lnk, mis, act;
    logic [31:0] mpc;
    logic [15:0] bcnt, mcnt;
    logic        pred2, tkn2, lnk2, mis2, act2;
    logic [31:0] mpc2;
    logic [1:0]  bcnt2, mcnt2;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .iCLK(clk), .iRSTn(rstn), .iLookupPC(lpc), .oPredTaken(pred),
        .iResolveValid(vld), .iBranch(br), .iStall(stl), .iOpcode(op),
        .iRt(rt), .iA(a), .iB(b), .iResolvePC(rpc), .iPredTaken(ptk),
        .oTaken(tkn), .oLink(lnk), .oMispredict(mis),
        .oMispredictPC(mpc), .oActualTaken(act),
        .oBranchCount(bcnt), .oMissCount(mcnt)
    );

    branch_predict_unit #(.CNT_W(2)) dut2 (
        .iCLK(clk), .iRSTn(rstn), .iLookupPC(lpc), .oPredTaken(pred2),
        .iResolveValid(vld), .iBranch(br), .iStall(stl), .iOpcode(op),
        .iRt(rt), .iA(a), .iB(b), .iResolvePC(rpc), .iPredTaken(ptk),
        .oTaken(tkn2), .oLink(lnk2), .oMispredict(mis2),
        .oMispredictPC(mpc2), .oActualTaken(act2),
        .oBranchCount(bcnt2), .oMissCount(mcnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] o,
                         input logic [4:0] r, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [31:0] pc,
                         input logic p);
        vld = v; br = 1'b1; op = o; rt = r;
        a = ia; b = ib; rpc = pc; ptk = p;
    endtask

    task automatic idle();
        vld = 1'b0; br = 1'b0; stl = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; idle(); lpc = 32'h0040_0010;
        step(); step();
        total++;
        if (pred !== 1'b0) begin
            bad++; $display("FAIL rst_pred got=%b exp=0", pred);
        end
        total++;
        if ({mis, act, tkn, lnk} !== 4'b0) begin
            bad++; $display("FAIL rst_flags got=%b exp=0000", {mis, act, tkn, lnk});
        end
        total++;
        if (mpc !== 32'h0 || bcnt !== 16'h0 || mcnt !== 16'h0) begin
            bad++;
            $display("FAIL rst_regs got=%h/%0d/%0d exp=0/0/0", mpc, bcnt, mcnt);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_train();
        drive(1'b1, 6'b000100, 5'd0, 32'd5, 32'd5, 32'h100, 1'b0);
        #1;
        total++;
        if (tkn !== 1'b1 || lnk !== 1'b0) begin
            bad++; $display("FAIL beq_comb got=%b%b exp=10", tkn, lnk);
        end
        step();
        idle(); lpc = 32'h100;
        #1;
        total++;
        if (mis !== 1'b1 || mpc !== 32'h100 || act !== 1'b1) begin
            bad++;
            $display("FAIL beq_pulse got=%b/%h/%b exp=1/100/1", mis, mpc, act);
        end
        total++;
        if (bcnt !== 16'd1 || mcnt !== 16'd1) begin
            bad++; $display("FAIL beq_cnt got=%0d/%0d exp=1/1", bcnt, mcnt);
        end
        total++;
        if (pred !== 1'b1) begin
            bad++; $display("FAIL beq_pred got=%b exp=1", pred);
        end
        drive(1'b1, 6'b000100, 5'd0, 32'd5, 32'd5, 32'h100, 1'b1);
        step(); step(); step();
        drive(1'b1, 6'b000100, 5'd0, 32'd5, 32'd6, 32'h100, 1'b0);
        #1;
        total++;
        if (tkn !== 1'b0) begin
            bad++; $display("FAIL beq_nt got=%b exp=0", tkn);
        end
        step();
        idle();
        #1;
        total++;
        if (mis !== 1'b0 || pred !== 1'b1) begin
            bad++; $display("FAIL nt_nopulse got=%b/%b exp=0/1", mis, pred);
        end
        total++;
        if (bcnt !== 16'd5 || mcnt !== 16'd1) begin
            bad++; $display("FAIL train_cnt got=%0d/%0d exp=5/1", bcnt, mcnt);
        end
        drive(1'b1, 6'b000100, 5'd0, 32'd5, 32'd6, 32'h100, 1'b0);
        step();
        idle();
        #1;
        total++;
        if (pred !== 1'b0 || bcnt !== 16'd6) begin
            bad++; $display("FAIL weak_nt got=%b/%0d exp=0/6", pred, bcnt);
        end
    endtask

    task automatic test_signed();
        drive(1'b0, 6'b000111, 5'd0, 32'h8000_0000, 32'd0, 32'h0, 1'b0);
        #1;
        total++;
        if (tkn !== 1'b0) begin
            bad++; $display("FAIL bgtz_neg got=%b exp=0", tkn);
        end
        a = 32'd1;
        #1;
        total++;
        if (tkn !== 1'b1) begin
            bad++; $display("FAIL bgtz_pos got=%b exp=1", tkn);
        end
        drive(1'b0, 6'b000110, 5'd0, 32'd0, 32'd0, 32'h0, 1'b0);
        #1;
        total++;
        if (tkn !== 1'b1) begin
            bad++; $display("FAIL blez_zero got=%b exp=1", tkn);
        end
        drive(1'b1, 6'b000111, 5'd3, 32'd5, 32'd0, 32'h20, 1'b1);
        #1;
        total++;
        if (tkn !== 1'b0) begin
            bad++; $display("FAIL bgtz_rt3 got=%b exp=0", tkn);
        end
        step();
        idle();
        #1;
        total++;
        if (bcnt !== 16'd6 || mis !== 1'b0) begin
            bad++; $display("FAIL rt3_nocount got=%0d/%b exp=6/0", bcnt, mis);
        end
        drive(1'b0, 6'b000001, 5'b10000, 32'hFFFF_FFFF, 32'd0, 32'h0, 1'b0);
        #1;
        total++;
        if (tkn !== 1'b1 || lnk !== 1'b1) begin
            bad++; $display("FAIL bltzal got=%b%b exp=11", tkn, lnk);
        end
        rt = 5'b10001;
        #1;
        total++;
        if (tkn !== 1'b0 || lnk !== 1'b1) begin
            bad++; $display("FAIL bgezal got=%b%b exp=01", tkn, lnk);
        end
        br = 1'b0;
        #1;
        total++;
        if (tkn !== 1'b0 || lnk !== 1'b0) begin
            bad++; $display("FAIL nobranch got=%b%b exp=00", tkn, lnk);
        end
        idle();
    endtask

    task automatic test_stall();
        drive(1'b1, 6'b000100, 5'd0, 32'd7, 32'd7, 32'h200, 1'b0);
        stl = 1'b1;
        step();
        total++;
        if (mis !== 1'b0 || bcnt !== 16'd6) begin
            bad++; $display("FAIL stall1 got=%b/%0d exp=0/6", mis, bcnt);
        end
        step();
        total++;
        if (mis !== 1'b0 || bcnt !== 16'd6) begin
            bad++; $display("FAIL stall2 got=%b/%0d exp=0/6", mis, bcnt);
        end
        stl = 1'b0;
        step();
        idle();
        total++;
        if (mis !== 1'b1 || mpc !== 32'h200 || bcnt !== 16'd7 || mcnt !== 16'd2) begin
            bad++;
            $display("FAIL stall_rel got=%b/%h/%0d/%0d exp=1/200/7/2",
                     mis, mpc, bcnt, mcnt);
        end
        step();
        total++;
        if (mis !== 1'b0 || mpc !== 32'h200 || act !== 1'b1) begin
            bad++; $display("FAIL pulse_end got=%b/%h/%b exp=0/200/1", mis, mpc, act);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 6'b000101, 5'd0, 32'd1, 32'd2, 32'h300, 1'b0);
        step();
        drive(1'b1, 6'b000001, 5'd0, 32'd1, 32'd0, 32'h304, 1'b1);
        total++;
        if (mis !== 1'b1 || mpc !== 32'h300 || act !== 1'b1) begin
            bad++; $display("FAIL b2b_1 got=%b/%h/%b exp=1/300/1", mis, mpc, act);
        end
        step();
        idle();
        total++;
        if (mis !== 1'b1 || mpc !== 32'h304 || act !== 1'b0) begin
            bad++; $display("FAIL b2b_2 got=%b/%h/%b exp=1/304/0", mis, mpc, act);
        end
        step();
        total++;
        if (mis !== 1'b0 || bcnt !== 16'd9 || mcnt !== 16'd4) begin
            bad++;
            $display("FAIL b2b_end got=%b/%0d/%0d exp=0/9/4", mis, bcnt, mcnt);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 6'b000100, 5'd0, 32'd3, 32'd3, 32'h100, 1'b0);
        lpc = 32'h100;
        rstn = 1'b0;
        step();
        idle();
        total++;
        if (mis !== 1'b0 || bcnt !== 16'd0 || mcnt !== 16'd0) begin
            bad++;
            $display("FAIL mid_rst got=%b/%0d/%0d exp=0/0/0", mis, bcnt, mcnt);
        end
        rstn = 1'b1;
        #1;
        total++;
        if (pred !== 1'b0) begin
            bad++; $display("FAIL mid_rst_pred got=%b exp=0", pred);
        end
        drive(1'b1, 6'b000100, 5'd0, 32'd3, 32'd3, 32'h100, 1'b0);
        step();
        idle();
        total++;
        if (pred !== 1'b1 || mis !== 1'b1 || bcnt !== 16'd1) begin
            bad++;
            $display("FAIL mid_rst_wk got=%b/%b/%0d exp=1/1/1", pred, mis, bcnt);
        end
    endtask

    task automatic test_saturation();
        drive(1'b1, 6'b000100, 5'd0, 32'd3, 32'd3, 32'h100, 1'b1);
        for (int i = 0; i < 5; i++) step();
        idle();
        total++;
        if (bcnt2 !== 2'd3 || mcnt2 !== 2'd1) begin
            bad++; $display("FAIL sat_cnt2 got=%0d/%0d exp=3/1", bcnt2, mcnt2);
        end
        total++;
        if (bcnt !== 16'd6 || mcnt !== 16'd1) begin
            bad++; $display("FAIL sat_cnt16 got=%0d/%0d exp=6/1", bcnt, mcnt);
        end
    endtask

    initial begin
        lpc = '0; op = '0; rt = '0; a = '0; b = '0; rpc = '0; ptk = 1'b0;
        vld = 1'b0; br = 1'b0; stl = 1'b0; rstn = 1'b0;
        test_reset();
        test_train();
        test_signed();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
